// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - ticket ejector and greedy coin hopper sequencer
//
// Purpose: after a sale/cancel, ejects ticket_count tickets and then returns
//          change_amount as coins, largest denomination first, one item per
//          valid/ready handshake. Pulses done once everything has gone out.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   start             one-cycle request, honoured only when idle
//   change_amount     dollars to return, latched on start
//   ticket_count      tickets to eject, latched on start
//   tkt_valid/ready   ticket ejector handshake
//   coin_valid/ready  coin hopper handshake, coin_value = denomination
//   busy              high whenever not idle
//   done              one-cycle completion pulse
//   coins_out         coins dispensed in the current/last transaction

module change_dispenser #(
    parameter int WIDTH  = 32,
    parameter int COIN_A = 50,
    parameter int COIN_B = 10,
    parameter int COIN_C = 5,
    parameter int COIN_D = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] change_amount,
    input  logic [WIDTH-1:0] ticket_count,
    output logic             tkt_valid,
    input  logic             tkt_ready,
    output logic             coin_valid,
    output logic [WIDTH-1:0] coin_value,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] coins_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TICKET = 2'd1,
        S_COIN   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] tickets_left_q, tickets_left_d;
    logic [WIDTH-1:0] coins_out_q, coins_out_d;
    logic             tkt_valid_q, tkt_valid_d;
    logic             coin_valid_q, coin_valid_d;
    logic [WIDTH-1:0] coin_value_q, coin_value_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] denom_cur;

    // Largest denomination not exceeding amt. With COIN_D == 1 any non-zero
    // amount finds a coin; the result is meaningless for amt == 0 and is
    // masked by the valid qualifier wherever it is used.
    function automatic logic [WIDTH-1:0] pick_denom(input logic [WIDTH-1:0] amt);
        if (amt >= WIDTH'(COIN_A)) begin
            return WIDTH'(COIN_A);
        end else if (amt >= WIDTH'(COIN_B)) begin
            return WIDTH'(COIN_B);
        end else if (amt >= WIDTH'(COIN_C)) begin
            return WIDTH'(COIN_C);
        end else begin
            return WIDTH'(COIN_D);
        end
    endfunction

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        tickets_left_d = tickets_left_q;
        coins_out_d    = coins_out_q;
        denom_cur      = pick_denom(remaining_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d    = change_amount;
                    tickets_left_d = ticket_count;
                    coins_out_d    = '0;
                    state_d        = S_TICKET;
                end
            end
            S_TICKET: begin
                if (tickets_left_q == '0) begin
                    state_d = S_COIN;
                end else if (tkt_valid_q && tkt_ready) begin
                    tickets_left_d = tickets_left_q - 1'b1;
                    if (tickets_left_q == WIDTH'(1)) begin
                        state_d = S_COIN;
                    end
                end
            end
            S_COIN: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if (coin_valid_q && coin_ready) begin
                    remaining_d = remaining_q - denom_cur;
                    coins_out_d = coins_out_q + 1'b1;
                    if (remaining_q == denom_cur) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they can be registered
        // without adding a cycle: after each edge they reflect the state just
        // entered, and ready never reaches valid combinationally.
        tkt_valid_d  = (state_d == S_TICKET) && (tickets_left_d != '0);
        coin_valid_d = (state_d == S_COIN) && (remaining_d != '0);
        coin_value_d = coin_valid_d ? pick_denom(remaining_d) : '0;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            remaining_q    <= '0;
            tickets_left_q <= '0;
            coins_out_q    <= '0;
            tkt_valid_q    <= 1'b0;
            coin_valid_q   <= 1'b0;
            coin_value_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            tickets_left_q <= tickets_left_d;
            coins_out_q    <= coins_out_d;
            tkt_valid_q    <= tkt_valid_d;
            coin_valid_q   <= coin_valid_d;
            coin_value_q   <= coin_value_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign tkt_valid  = tkt_valid_q;
    assign coin_valid = coin_valid_q;
    assign coin_value = coin_value_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign coins_out  = coins_out_q;

endmodule
